// File: rtl/sram_1rw_model.sv
// Parametrised 1RW SRAM simulation model with a per-lane write mask, a 1..4 stage
// read pipeline with valid, no-change / write-through output modes and a sticky range error.

module sram_lane_merge #(
    parameter int GRAN = 8
) (
    input  logic [GRAN-1:0] old_lane,
    input  logic [GRAN-1:0] new_lane,
    input  logic            keep,
    output logic [GRAN-1:0] merged
);
    assign merged = keep ? old_lane : new_lane;
endmodule

module sram_1rw_model #(
    parameter  int WIDTH        = 32,
    parameter  int DEPTH        = 512,
    parameter  int MASK_GRAN    = 8,
    parameter  int READ_LATENCY = 1,
    parameter  int WRITE_MODE   = 0,
    localparam int NLANE        = WIDTH / MASK_GRAN,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic             CE,
    input  logic             RSTB,
    input  logic [AW-1:0]    A,
    input  logic             CSB,
    input  logic             WEB,
    input  logic             OEB,
    input  logic [NLANE-1:0] BWEB,
    input  logic [WIDTH-1:0] I,
    output tri   [WIDTH-1:0] O,
    output logic             OV,
    output logic             ERR
);
    localparam int           STAGES  = READ_LATENCY - 1;
    localparam logic [AW:0]  DEPTH_L = (AW+1)'(DEPTH);

    if (WIDTH % MASK_GRAN != 0) begin : g_bad_gran
        $error("sram_1rw_model: WIDTH must be a multiple of MASK_GRAN");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
        $error("sram_1rw_model: READ_LATENCY must be 1..4");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("sram_1rw_model: DEPTH must be >= 2");
    end
    if (WRITE_MODE != 0 && WRITE_MODE != 1) begin : g_bad_mode
        $error("sram_1rw_model: WRITE_MODE must be 0 or 1");
    end

    logic [WIDTH-1:0] mem [DEPTH];

    logic                            re, we, in_range, ld;
    logic [WIDTH-1:0]                old_word, ld_data;
    logic [NLANE-1:0][MASK_GRAN-1:0] old_lanes, new_lanes, mrg_lanes;
    logic [STAGES:0][WIDTH-1:0]      data_pipe;
    logic [STAGES:0]                 vld_pipe;

    assign re       = ~CSB & WEB;
    assign we       = ~CSB & ~WEB;
    assign in_range = ({1'b0, A} < DEPTH_L);
    assign old_word = in_range ? mem[A] : '0;

    assign old_lanes = old_word;
    assign new_lanes = I;

    for (genvar k = 0; k < NLANE; k++) begin : g_lane
        sram_lane_merge #(.GRAN(MASK_GRAN)) u_merge (
            .old_lane (old_lanes[k]),
            .new_lane (new_lanes[k]),
            .keep     (BWEB[k]),
            .merged   (mrg_lanes[k])
        );
    end

    // Out-of-range accesses of either kind present zeros, never a stale or aliased word.
    assign ld      = (WRITE_MODE == 1) ? (re | we) : re;
    assign ld_data = !in_range ? '0 : (we ? WIDTH'(mrg_lanes) : old_word);

    // Array has no reset; accesses sampled during reset are dropped.
    always_ff @(posedge CE) begin
        if (RSTB && we && in_range)
            mem[A] <= mrg_lanes;
    end

    always_ff @(posedge CE or negedge RSTB) begin
        if (!RSTB) begin
            data_pipe <= '0;
            vld_pipe  <= '0;
            ERR       <= 1'b0;
        end else begin
            if (ld)
                data_pipe[0] <= ld_data;
            vld_pipe[0] <= ld;
            for (int s = 1; s <= STAGES; s++) begin
                data_pipe[s] <= data_pipe[s-1];
                vld_pipe[s]  <= vld_pipe[s-1];
            end
            if ((re | we) && !in_range)
                ERR <= 1'b1;
        end
    end

    assign O  = OEB ? 'z : data_pipe[STAGES];
    assign OV = vld_pipe[STAGES];
endmodule
